data_memory: RTL and testbench

Register-file-plus-ALU execute datapath for the single-cycle RISC-V core. It reads two source registers, selects the second operand from a register or a sign-extended 12-bit immediate, and performs the operation chosen by the externally decoded `Opsel`. It writes the result back to `rd` on the clock edge and exposes the result and a zero flag to branch and control logic.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/alu.sv | 36 +++
 rtl/data_memory.sv | 54 +++++
 tb/tb_data_memory.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I datapath constants, opcodes and ALU operation codes
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SRL  = 4'b0010,
        ALU_SRA  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_XOR  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_op_t;

    // Sign-extend an I-type 12-bit immediate to the full datapath width.
    function automatic logic [XLEN-1:0] sext_imm12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational RV32I ALU with zero flag
module alu
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      opsel,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    // Select the operation; the unassigned codes 1010-1111 yield zero.
    always_comb begin
        result = '0;
        case (alu_op_t'(opsel))
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  result = a ^ b;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - register file plus ALU execute stage with write-back
module data_memory
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    input  logic [6:0]      opcode,
    input  logic [3:0]      Opsel,
    input  logic [11:0]     imm_in,
    input  logic            reg_write,
    output logic [XLEN-1:0] ALU_out,
    output logic            zero_flag
);

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] rs2_val;
    logic            write_en;

    // x0 is hard-wired to zero regardless of storage contents.
    assign op_a    = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

    // OP-IMM takes the sign-extended immediate; every other opcode uses rs2.
    assign op_b = (opcode == OP_IMM) ? sext_imm12(imm_in) : rs2_val;

    // Only R-type and OP-IMM results retire to the register file, never to x0.
    assign write_en = reg_write && (rd != 5'd0) &&
                      ((opcode == OP_R) || (opcode == OP_IMM));

    alu u_alu (
        .a      (op_a),
        .b      (op_b),
        .opsel  (Opsel),
        .result (ALU_out),
        .zero   (zero_flag)
    );

    // Register file: reset preloads each entry with its own index, then writes retire on the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= XLEN'(i);
            end
        end else if (write_en) begin
            regs[rd] <= ALU_out;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - table-driven self-checking bench for data_memory
module tb_data_memory;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] I   = 7'b0010011;
    localparam logic [6:0] UND = 7'b0000011;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [3:0]  Opsel;
    logic [11:0] imm_in;
    logic        reg_write;
    logic [31:0] ALU_out;
    logic        zero_flag;

    int checks;
    int errors;

    typedef struct {
        logic [6:0]  opcode;
        logic [3:0]  opsel;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] exp_out;
        logic        exp_zero;
    } vec_t;

    vec_t vecs [$];

    data_memory dut (
        .clk       (clk),
        .reset     (reset),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .opcode    (opcode),
        .Opsel     (Opsel),
        .imm_in    (imm_in),
        .reg_write (reg_write),
        .ALU_out   (ALU_out),
        .zero_flag (zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input string name, input logic [31:0] exp_out, input logic exp_zero);
        checks++;
        if (ALU_out !== exp_out) begin
            errors++;
            $display("FAIL %s ALU_out got %h expected %h", name, ALU_out, exp_out);
        end
        checks++;
        if (zero_flag !== exp_zero) begin
            errors++;
            $display("FAIL %s zero_flag got %b expected %b", name, zero_flag, exp_zero);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [3:0] sel, input logic [4:0] a,
                         input logic [4:0] b, input logic [11:0] imm, input logic [4:0] d,
                         input logic we);
        opcode = op; Opsel = sel; rs1 = a; rs2 = b; imm_in = imm; rd = d; reg_write = we;
    endtask

    task automatic add_vec(input logic [6:0] op, input logic [3:0] sel, input logic [4:0] a,
                           input logic [4:0] b, input logic [11:0] imm, input logic [4:0] d,
                           input logic we, input logic [31:0] e, input logic z);
        vec_t v;
        v.opcode = op; v.opsel = sel; v.rs1 = a; v.rs2 = b; v.imm = imm;
        v.rd = d; v.we = we; v.exp_out = e; v.exp_zero = z;
        vecs.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        drive(R, 4'd0, 5'd0, 5'd0, 12'd0, 5'd0, 1'b0);

        // Each vector is applied after a falling edge, checked 1ns later, then one rising edge passes.
        add_vec(R,   4'd0, 5'd31, 5'd0,  12'h000, 5'd0,  1'b0, 32'd31,       1'b0); // reset contents
        add_vec(R,   4'd0, 5'd1,  5'd2,  12'h000, 5'd0,  1'b1, 32'd3,        1'b0); // write to x0 dropped
        add_vec(R,   4'd0, 5'd0,  5'd0,  12'h000, 5'd0,  1'b0, 32'd0,        1'b1); // x0 still 0
        add_vec(R,   4'd1, 5'd17, 5'd16, 12'h000, 5'd18, 1'b1, 32'd1,        1'b0); // x18 <= 1
        add_vec(R,   4'd0, 5'd18, 5'd0,  12'h000, 5'd0,  1'b0, 32'd1,        1'b0);
        add_vec(I,   4'd0, 5'd21, 5'd31, 12'hFFB, 5'd20, 1'b1, 32'd16,       1'b0); // 21 + (-5)
        add_vec(R,   4'd0, 5'd20, 5'd0,  12'h000, 5'd0,  1'b0, 32'd16,       1'b0);
        add_vec(I,   4'd2, 5'd24, 5'd0,  12'h002, 5'd0,  1'b0, 32'd6,        1'b0);
        add_vec(R,   4'd4, 5'd2,  5'd3,  12'h000, 5'd0,  1'b0, 32'd16,       1'b0);
        add_vec(R,   4'd9, 5'd9,  5'd10, 12'h000, 5'd0,  1'b0, 32'd8,        1'b0);
        add_vec(R,   4'd1, 5'd5,  5'd5,  12'h000, 5'd7,  1'b0, 32'd0,        1'b1); // no write, reg_write=0
        add_vec(R,   4'd0, 5'd7,  5'd0,  12'h000, 5'd0,  1'b0, 32'd7,        1'b0);
        add_vec(R,   4'hF, 5'd3,  5'd4,  12'h000, 5'd0,  1'b0, 32'd0,        1'b1);
        add_vec(R,   4'hA, 5'd3,  5'd4,  12'h000, 5'd0,  1'b0, 32'd0,        1'b1);
        add_vec(I,   4'd0, 5'd0,  5'd0,  12'h800, 5'd25, 1'b1, 32'hFFFFF800, 1'b0); // x25 <= -2048
        add_vec(R,   4'd3, 5'd25, 5'd4,  12'h000, 5'd0,  1'b0, 32'hFFFFFF80, 1'b0);
        add_vec(R,   4'd2, 5'd25, 5'd4,  12'h000, 5'd0,  1'b0, 32'h0FFFFF80, 1'b0);
        add_vec(R,   4'd5, 5'd25, 5'd1,  12'h000, 5'd0,  1'b0, 32'd1,        1'b0);
        add_vec(R,   4'd6, 5'd25, 5'd1,  12'h000, 5'd0,  1'b0, 32'd0,        1'b1);
        add_vec(R,   4'd7, 5'd6,  5'd3,  12'h000, 5'd0,  1'b0, 32'd5,        1'b0);
        add_vec(R,   4'd8, 5'd8,  5'd4,  12'h000, 5'd0,  1'b0, 32'd12,       1'b0);
        add_vec(R,   4'd1, 5'd1,  5'd2,  12'h000, 5'd0,  1'b0, 32'hFFFFFFFF, 1'b0); // wraps
        add_vec(R,   4'd0, 5'd31, 5'd31, 12'h000, 5'd0,  1'b0, 32'd62,       1'b0);
        add_vec(UND, 4'd0, 5'd3,  5'd4,  12'h7FF, 5'd26, 1'b1, 32'd7,        1'b0); // B from rs2, no write
        add_vec(R,   4'd0, 5'd26, 5'd0,  12'h000, 5'd0,  1'b0, 32'd26,       1'b0);

        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].opcode, vecs[i].opsel, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].imm, vecs[i].rd, vecs[i].we);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_zero);
        end

        // No bypass: x1 + x2 reads old x1 before the edge, new x1 right after it.
        @(negedge clk);
        drive(R, 4'd0, 5'd1, 5'd2, 12'h000, 5'd1, 1'b1);
        #1;
        check_out("nobypass_pre", 32'd3, 1'b0);
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        check_out("nobypass_post", 32'd5, 1'b0);

        // Write x5 = 100, then reset asynchronously mid-cycle.
        @(negedge clk);
        drive(I, 4'd0, 5'd0, 5'd0, 12'd100, 5'd5, 1'b1);
        @(negedge clk);
        drive(R, 4'd0, 5'd5, 5'd0, 12'h000, 5'd0, 1'b0);
        #1;
        check_out("x5_written", 32'd100, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check_out("async_reset_x5", 32'd5, 1'b0);

        // A write attempted while reset is held must be ignored.
        drive(I, 4'd0, 5'd0, 5'd0, 12'd55, 5'd6, 1'b1);
        @(posedge clk);
        #1;
        drive(R, 4'd0, 5'd6, 5'd0, 12'h000, 5'd0, 1'b0);
        #1;
        check_out("write_in_reset", 32'd6, 1'b0);

        // First edge after reset falls performs the write.
        @(negedge clk);
        reset = 1'b0;
        drive(I, 4'd0, 5'd0, 5'd0, 12'd55, 5'd6, 1'b1);
        @(posedge clk);
        #1;
        drive(R, 4'd0, 5'd6, 5'd0, 12'h000, 5'd0, 1'b0);
        #1;
        check_out("first_write_after_reset", 32'd55, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
